// File: rtl/aes_block_sequencer_if.sv
// Job-control, input-block, core and output-block signals of the AES block sequencer.
// slave: the sequencer itself. master: the surrounding adapters, the core and the bench.
interface aes_block_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [1:0]       mode;
  logic             decrypt;
  logic [CNT_W-1:0] num_blocks;
  logic [127:0]     iv;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_block;
  logic             core_start;
  logic             core_decrypt;
  logic [127:0]     core_in;
  logic             core_done;
  logic [127:0]     core_out;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_block;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] blocks_done;

  modport slave (
    input  start, abort, mode, decrypt, num_blocks, iv,
    input  in_valid, in_block, core_done, core_out, out_ready,
    output in_ready, core_start, core_decrypt, core_in,
    output out_valid, out_block, busy, done, blocks_done
  );

  modport master (
    output start, abort, mode, decrypt, num_blocks, iv,
    output in_valid, in_block, core_done, core_out, out_ready,
    input  in_ready, core_start, core_decrypt, core_in,
    input  out_valid, out_block, busy, done, blocks_done
  );
endinterface

// File: rtl/aes_block_sequencer.sv
// AES job sequencer: moves N 128-bit blocks, one at a time, from the input
// block builder through a single-block AES core to the output splitter,
// applying ECB / CBC / CTR chaining around the core.
module aes_block_sequencer #(
  parameter int CNT_W = 16,
  parameter int CTR_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  aes_block_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_CORE = 3'd2;
  localparam logic [2:0] S_OUTP = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [1:0] M_CBC = 2'd1;
  localparam logic [1:0] M_CTR = 2'd2;

  logic [2:0]       state;
  logic [1:0]       mode_q;
  logic             dec_q;
  logic [CNT_W-1:0] nblk_q;
  logic [CNT_W-1:0] bdone_q;
  logic [127:0]     chain_q;
  logic [127:0]     hold_q;
  logic [127:0]     core_in_q;
  logic [127:0]     out_q;
  logic             out_valid_q;
  logic             core_start_q;
  logic             done_q;

  logic             is_cbc, is_ctr;
  logic [127:0]     core_in_nxt;
  logic [127:0]     out_nxt;
  logic [127:0]     chain_nxt;
  logic [CNT_W-1:0] bdone_inc;

  // reserved mode 3 falls through to plain ECB behaviour
  assign is_cbc    = (mode_q == M_CBC);
  assign is_ctr    = (mode_q == M_CTR);
  assign bdone_inc = bdone_q + {{(CNT_W-1){1'b0}}, 1'b1};

  assign bus.in_ready     = (state == S_LOAD);
  assign bus.busy         = (state != S_IDLE);
  assign bus.core_start   = core_start_q;
  assign bus.core_decrypt = dec_q & ~is_ctr;
  assign bus.core_in      = core_in_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_block    = out_q;
  assign bus.done         = done_q;
  assign bus.blocks_done  = bdone_q;

  // core operand for the block being accepted
  always_comb begin
    core_in_nxt = bus.in_block;
    if (is_ctr)
      core_in_nxt = chain_q;
    else if (is_cbc && !dec_q)
      core_in_nxt = bus.in_block ^ chain_q;
  end

  // output block and next chain value when the core result is captured
  always_comb begin
    out_nxt   = bus.core_out;
    chain_nxt = chain_q;
    if (is_ctr) begin
      out_nxt                  = bus.core_out ^ hold_q;
      chain_nxt[CTR_W-1:0]     = chain_q[CTR_W-1:0] + {{(CTR_W-1){1'b0}}, 1'b1};
    end else if (is_cbc && dec_q) begin
      out_nxt   = bus.core_out ^ chain_q;
      chain_nxt = hold_q;
    end else if (is_cbc) begin
      chain_nxt = bus.core_out;
    end
  end

  // job FSM and datapath registers; abort overrides everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      mode_q       <= 2'd0;
      dec_q        <= 1'b0;
      nblk_q       <= '0;
      bdone_q      <= '0;
      chain_q      <= '0;
      hold_q       <= '0;
      core_in_q    <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else if (bus.abort) begin
      state        <= S_IDLE;
      out_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          mode_q  <= bus.mode;
          dec_q   <= bus.decrypt;
          nblk_q  <= bus.num_blocks;
          chain_q <= bus.iv;
          bdone_q <= '0;
          state   <= (bus.num_blocks == '0) ? S_FIN : S_LOAD;
        end
        S_LOAD: if (bus.in_valid) begin
          hold_q       <= bus.in_block;
          core_in_q    <= core_in_nxt;
          core_start_q <= 1'b1;
          state        <= S_CORE;
        end
        S_CORE: if (bus.core_done) begin
          out_q       <= out_nxt;
          out_valid_q <= 1'b1;
          chain_q     <= chain_nxt;
          state       <= S_OUTP;
        end
        S_OUTP: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          bdone_q     <= bdone_inc;
          state       <= (bdone_inc == nblk_q) ? S_FIN : S_LOAD;
        end
        S_FIN: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Directed bench for aes_block_sequencer with a 3-cycle XOR core model and an
// expected-output queue filled when blocks are sent and drained on output.
module tb_aes_block_sequencer;
  localparam int           CNT_W = 16;
  localparam logic [127:0] K     = {16{8'hA5}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_block_sequencer_if #(.CNT_W(CNT_W)) bus();
  aes_block_sequencer #(.CNT_W(CNT_W), .CTR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  // core model: result = operand ^ A5.., core_done three cycles after core_start
  logic [2:0]   cpipe;
  logic [127:0] cdata;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cpipe <= '0;
      cdata <= '0;
    end else begin
      cpipe <= {cpipe[1:0], bus.core_start};
      if (bus.core_start) cdata <= bus.core_in ^ K;
    end
  end
  assign bus.core_done = cpipe[2];
  assign bus.core_out  = cdata;

  // count done pulses
  int done_cnt = 0;
  always @(posedge clk) if (bus.done) done_cnt <= done_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start_job(input logic [1:0] m, input logic d, input logic [CNT_W-1:0] n,
                           input logic [127:0] v);
    bus.mode = m; bus.decrypt = d; bus.num_blocks = n; bus.iv = v;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // offer block p, then check the core launch one cycle after the handshake
  task automatic send(input string tag, input logic [127:0] p, input logic [127:0] exp_cin);
    int i = 0;
    bus.in_valid = 1'b1;
    bus.in_block = p;
    while (!bus.in_ready && i < 50) begin step(); i++; end
    chk({tag, "_in_ready"}, {127'd0, bus.in_ready}, 128'd1);
    step();
    bus.in_valid = 1'b0;
    chk({tag, "_core_start"}, {127'd0, bus.core_start}, 128'd1);
    chk({tag, "_core_in"}, bus.core_in, exp_cin);
  endtask

  // wait for an output block and compare against the scoreboard head
  task automatic recv(input string tag);
    int i = 0;
    logic [127:0] e;
    while (!bus.out_valid && i < 50) begin step(); i++; end
    chk({tag, "_out_valid"}, {127'd0, bus.out_valid}, 128'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 128'd0;
    chk({tag, "_out_block"}, bus.out_block, e);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i = 0;
    while (!bus.done && i < 50) begin step(); i++; end
    chk({tag, "_done"}, {127'd0, bus.done}, 128'd1);
    chk({tag, "_busy_at_done"}, {127'd0, bus.busy}, 128'd0);
  endtask

  initial begin
    logic [127:0] ones, c, cin, p, ob, iv;
    int d0;
    bit ok;
    ones = '1;
    bus.start = 0; bus.abort = 0; bus.mode = 0; bus.decrypt = 0; bus.num_blocks = 0;
    bus.iv = 0; bus.in_valid = 0; bus.in_block = 0; bus.out_ready = 0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();

    // reset state
    chk("rst_busy",        {127'd0, bus.busy},       128'd0);
    chk("rst_in_ready",    {127'd0, bus.in_ready},   128'd0);
    chk("rst_out_valid",   {127'd0, bus.out_valid},  128'd0);
    chk("rst_core_start",  {127'd0, bus.core_start}, 128'd0);
    chk("rst_done",        {127'd0, bus.done},       128'd0);
    chk("rst_blocks_done", {112'd0, bus.blocks_done}, 128'd0);

    // ECB, two blocks
    d0 = done_cnt;
    start_job(2'd0, 1'b0, 16'd2, 128'd0);
    exp_q.push_back({16{8'hA5}});
    send("ecb0", 128'd0, 128'd0);
    recv("ecb0");
    chk("ecb_in_ready_after_out", {127'd0, bus.in_ready}, 128'd1);
    exp_q.push_back({16{8'h5A}});
    send("ecb1", ones, ones);
    recv("ecb1");
    wait_done("ecb");
    step(); step();
    chk("ecb_done_count", done_cnt - d0, 128'd1);
    chk("ecb_blocks_done", {112'd0, bus.blocks_done}, 128'd2);

    // CBC encrypt, iv=1, two zero blocks
    start_job(2'd1, 1'b0, 16'd2, 128'd1);
    chk("cbce_core_decrypt", {127'd0, bus.core_decrypt}, 128'd0);
    exp_q.push_back({{15{8'hA5}}, 8'hA4});
    send("cbce0", 128'd0, 128'd1);
    recv("cbce0");
    c = {{15{8'hA5}}, 8'hA4};
    exp_q.push_back(c ^ K);
    send("cbce1", 128'd0, c);
    recv("cbce1");
    wait_done("cbce");

    // CBC decrypt: out = core(P) ^ C, chain takes the ciphertext
    iv = {$urandom, $urandom, $urandom, $urandom};
    start_job(2'd1, 1'b1, 16'd2, iv);
    chk("cbcd_core_decrypt", {127'd0, bus.core_decrypt}, 128'd1);
    c = iv;
    for (int b = 0; b < 2; b++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(p ^ K ^ c);
      send("cbcd", p, p);
      recv("cbcd");
      c = p;
    end
    wait_done("cbcd");

    // CTR with low-word wrap; decrypt input must not reach the core
    start_job(2'd2, 1'b1, 16'd2, 128'h0000_0001_FFFF_FFFF);
    chk("ctr_core_decrypt", {127'd0, bus.core_decrypt}, 128'd0);
    cin = 128'h0000_0001_FFFF_FFFF;
    p = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(cin ^ K ^ p);
    send("ctr0", p, cin);
    recv("ctr0");
    cin = 128'h0000_0001_0000_0000;
    p = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(cin ^ K ^ p);
    send("ctr1", p, cin);
    recv("ctr1");
    wait_done("ctr");

    // output backpressure for 10 cycles
    start_job(2'd0, 1'b0, 16'd1, 128'd0);
    p = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    exp_q.push_back(p ^ K);
    send("bp", p, p);
    for (int i = 0; i < 50 && !bus.out_valid; i++) step();
    ob = bus.out_block;
    ok = bus.out_valid;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!bus.out_valid || bus.out_block !== ob || bus.in_ready) ok = 1'b0;
    end
    chk("bp_stable", {127'd0, ok}, 128'd1);
    recv("bp");
    wait_done("bp");

    // zero-block job: done two cycles after start, no block traffic
    d0 = done_cnt;
    start_job(2'd0, 1'b0, 16'd0, 128'd0);
    chk("zero_done_early", {127'd0, bus.done}, 128'd0);
    chk("zero_no_in_ready", {127'd0, bus.in_ready | bus.core_start}, 128'd0);
    step();
    chk("zero_done", {127'd0, bus.done}, 128'd1);
    chk("zero_busy", {127'd0, bus.busy}, 128'd0);
    step();
    chk("zero_done_one_cycle", {127'd0, bus.done}, 128'd0);

    // abort while the core is working; late core_done must be dropped
    start_job(2'd0, 1'b0, 16'd2, 128'd0);
    send("abort", 128'd7, 128'd7);
    d0 = done_cnt;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_busy", {127'd0, bus.busy}, 128'd0);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.out_valid || bus.busy || bus.core_start || bus.done) ok = 1'b0;
    end
    chk("abort_quiet", {127'd0, ok}, 128'd1);
    chk("abort_no_done", done_cnt - d0, 128'd0);
    chk("abort_blocks_done_hold", {112'd0, bus.blocks_done}, 128'd0);
    start_job(2'd0, 1'b0, 16'd1, 128'd0);
    exp_q.push_back(128'd9 ^ K);
    send("after_abort", 128'd9, 128'd9);
    recv("after_abort");
    wait_done("after_abort");
    chk("after_abort_blocks_done", {112'd0, bus.blocks_done}, 128'd1);

    // start and abort together in IDLE: nothing starts
    bus.num_blocks = 16'd1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", {127'd0, bus.busy}, 128'd0);
    chk("start_abort_in_ready", {127'd0, bus.in_ready}, 128'd0);

    chk("scoreboard_empty", exp_q.size(), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
